// File: rtl/ec_gf2m_pkg.sv
// Shared constants for the GF(2^3) EC-ElGamal decryption core: field size,
// reduction polynomial, curve coefficients and the controller state encoding.
package ec_gf2m_pkg;

    localparam int N = 3;
    localparam logic [N:0] F_POLY = 4'b1011;
    localparam logic [N-1:0] A = 3'd1;
    localparam logic [N-1:0] B = 3'd1;

    typedef enum logic [2:0] {
        StLoad,
        StNorm,
        StMul,
        StNeg,
        StAdd,
        StDone
    } state_e;

endpackage

// File: rtl/gf2m_mul.sv
// Combinational GF(2^N) multiplier: carry-less product reduced modulo F_POLY.
module gf2m_mul
    import ec_gf2m_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    logic [2*N-2:0] acc;

    // Shift-and-xor product, then fold the high terms back down from the top bit.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) acc = acc ^ ((2 * N - 1)'(a) << i);
        end
        for (int i = 2 * N - 2; i >= N; i--) begin
            if (acc[i]) acc[i-N +: N+1] = acc[i-N +: N+1] ^ F_POLY;
        end
        p = acc[N-1:0];
    end

endmodule

// File: rtl/ec_elgamal_decrypt.sv
// EC-ElGamal decryption P = C2 - ds*C1 over GF(2^3), curve y^2+xy = x^3+x^2+1.
// One shared field multiplier; every point operation runs as an 8-step sequence.
module ec_elgamal_decrypt
    import ec_gf2m_pkg::*;
#(
    parameter int unsigned Ds = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] x_C1,
    input  logic [N-1:0] y_C1,
    input  logic [N-1:0] z_C1,
    input  logic [N-1:0] x_C2,
    input  logic [N-1:0] y_C2,
    input  logic [N-1:0] z_C2,
    output logic [N-1:0] x_Plaintext,
    output logic [N-1:0] y_Plaintext,
    output logic [N-1:0] z_Plaintext,
    output logic         Decryption_ready
);

    localparam int BitW = $clog2(N + 1);
    localparam logic [N:0] DsBits = (N + 1)'(Ds);
    localparam logic [N-1:0] One = N'(1);

    state_e state_q;
    logic [2:0] step_q;
    logic pt_q;
    logic add_ph_q;
    logic [BitW-1:0] bit_q;

    // Raw copies of the inputs, kept for change detection in DONE.
    logic [N-1:0] rx1_q, ry1_q, rz1_q, rx2_q, ry2_q, rz2_q;
    // Affine points: C1, C2, accumulator Q and result P.
    logic [N-1:0] c1x_q, c1y_q, c2x_q, c2y_q, qx_q, qy_q, px_q, py_q;
    logic c1i_q, c2i_q, qi_q, pi_q;
    // Point-operation scratch registers.
    logic [N-1:0] t0_q, t1_q, lam_q, num_q, den_q, x3_q;
    logic dbl_q;

    logic [N-1:0] ma, mb, mp;
    logic [N-1:0] op_ax, op_ay, op_bx, op_by;
    logic op_ai, op_bi;
    logic [N-1:0] nx, ny, nz;
    logic norm_inf, norm_last;
    logic same_x, op_done, res_i, changed;
    logic [N-1:0] x3_c, y3_c, res_x, res_y;

    gf2m_mul u_mul (
        .a(ma),
        .b(mb),
        .p(mp)
    );

    // Operand selection for the point operation: Q+Q / Q+C1 in MUL, C2+(-Q) in ADD.
    always_comb begin
        op_ax = qx_q;
        op_ay = qy_q;
        op_ai = qi_q;
        op_bx = qx_q;
        op_by = qy_q;
        op_bi = qi_q;
        if (state_q == StMul && add_ph_q) begin
            op_bx = c1x_q;
            op_by = c1y_q;
            op_bi = c1i_q;
        end else if (state_q == StAdd) begin
            op_ax = c2x_q;
            op_ay = c2y_q;
            op_ai = c2i_q;
        end
        nx = pt_q ? rx2_q : rx1_q;
        ny = pt_q ? ry2_q : ry1_q;
        nz = pt_q ? rz2_q : rz1_q;
        norm_inf = (nz == '0);
        norm_last = norm_inf || (step_q == 3'd4);
        same_x = (op_ax == op_bx);
        changed = {x_C1, y_C1, z_C1, x_C2, y_C2, z_C2} !=
                  {rx1_q, ry1_q, rz1_q, rx2_q, ry2_q, rz2_q};
    end

    // Multiplier operand schedule; Z^-1 and den^-1 are both built as s^2 * s^4.
    always_comb begin
        ma = '0;
        mb = '0;
        if (state_q == StNorm) begin
            case (step_q)
                3'd0: begin ma = nz; mb = nz; end
                3'd1: begin ma = t0_q; mb = t0_q; end
                3'd2: begin ma = t0_q; mb = t1_q; end
                3'd3: begin ma = nx; mb = t1_q; end
                3'd4: begin ma = ny; mb = t1_q; end
                default: ;
            endcase
        end else begin
            case (step_q)
                3'd1: begin ma = den_q; mb = den_q; end
                3'd2: begin ma = t0_q; mb = t0_q; end
                3'd3: begin ma = t0_q; mb = t1_q; end
                3'd4: begin ma = num_q; mb = t1_q; end
                3'd5: begin ma = lam_q; mb = lam_q; end
                3'd6: begin ma = op_ax; mb = op_ax; end
                3'd7: begin
                    ma = dbl_q ? (lam_q ^ One) : lam_q;
                    mb = dbl_q ? x3_q : (op_ax ^ x3_q);
                end
                default: ;
            endcase
        end
    end

    // Special cases resolve in step 0; the generic formula finishes in step 7.
    always_comb begin
        x3_c = t0_q ^ lam_q ^ A ^ (dbl_q ? '0 : (op_ax ^ op_bx));
        y3_c = dbl_q ? (t1_q ^ mp) : (mp ^ x3_q ^ op_ay);
        op_done = 1'b0;
        res_x = x3_q;
        res_y = y3_c;
        res_i = 1'b0;
        if (step_q == 3'd0) begin
            if (op_ai) begin
                op_done = 1'b1;
                res_x = op_bx;
                res_y = op_by;
                res_i = op_bi;
            end else if (op_bi) begin
                op_done = 1'b1;
                res_x = op_ax;
                res_y = op_ay;
                res_i = 1'b0;
            end else if (same_x && (op_ay != op_by || op_ax == '0)) begin
                op_done = 1'b1;
                res_x = '0;
                res_y = '0;
                res_i = 1'b1;
            end
        end else if (step_q == 3'd7) begin
            op_done = 1'b1;
        end
    end

    // Controller and datapath state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLoad;
            step_q <= '0;
            pt_q <= 1'b0;
            add_ph_q <= 1'b0;
            bit_q <= '0;
            {rx1_q, ry1_q, rz1_q, rx2_q, ry2_q, rz2_q} <= '0;
            {c1x_q, c1y_q, c2x_q, c2y_q, qx_q, qy_q, px_q, py_q} <= '0;
            {c1i_q, c2i_q, qi_q, pi_q} <= '0;
            {t0_q, t1_q, lam_q, num_q, den_q, x3_q} <= '0;
            dbl_q <= 1'b0;
            x_Plaintext <= '0;
            y_Plaintext <= '0;
            z_Plaintext <= '0;
            Decryption_ready <= 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    {rx1_q, ry1_q, rz1_q} <= {x_C1, y_C1, z_C1};
                    {rx2_q, ry2_q, rz2_q} <= {x_C2, y_C2, z_C2};
                    step_q <= '0;
                    pt_q <= 1'b0;
                    state_q <= StNorm;
                end
                StNorm: begin
                    step_q <= step_q + 3'd1;
                    case (step_q)
                        3'd0: t0_q <= mp;
                        3'd1: t1_q <= mp;
                        3'd2: t1_q <= mp;
                        3'd3: if (pt_q) c2x_q <= mp; else c1x_q <= mp;
                        default: if (pt_q) c2y_q <= mp; else c1y_q <= mp;
                    endcase
                    if (norm_last) begin
                        if (pt_q) c2i_q <= norm_inf;
                        else c1i_q <= norm_inf;
                        step_q <= '0;
                        if (pt_q) begin
                            state_q <= StMul;
                            bit_q <= BitW'(N);
                            add_ph_q <= 1'b0;
                            qx_q <= '0;
                            qy_q <= '0;
                            qi_q <= 1'b1;
                        end else begin
                            pt_q <= 1'b1;
                        end
                    end
                end
                StMul, StAdd: begin
                    if (op_done) begin
                        step_q <= '0;
                        if (state_q == StAdd) begin
                            px_q <= res_x;
                            py_q <= res_y;
                            pi_q <= res_i;
                            state_q <= StDone;
                        end else begin
                            qx_q <= res_x;
                            qy_q <= res_y;
                            qi_q <= res_i;
                            // After each doubling, add C1 only if this scalar bit is set.
                            if (!add_ph_q && DsBits[bit_q]) begin
                                add_ph_q <= 1'b1;
                            end else begin
                                add_ph_q <= 1'b0;
                                if (bit_q == '0) state_q <= StNeg;
                                else bit_q <= bit_q - 1'b1;
                            end
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                        case (step_q)
                            3'd0: begin
                                dbl_q <= same_x;
                                den_q <= same_x ? op_ax : (op_ax ^ op_bx);
                                num_q <= same_x ? op_ay : (op_ay ^ op_by);
                            end
                            3'd1: t0_q <= mp;
                            3'd2: t1_q <= mp;
                            3'd3: t1_q <= mp;
                            3'd4: lam_q <= dbl_q ? (op_ax ^ mp) : mp;
                            3'd5: t0_q <= mp;
                            3'd6: begin
                                x3_q <= x3_c;
                                t1_q <= mp;
                            end
                            default: ;
                        endcase
                    end
                end
                StNeg: begin
                    if (!qi_q) qy_q <= qx_q ^ qy_q;
                    step_q <= '0;
                    state_q <= StAdd;
                end
                StDone: begin
                    if (changed) begin
                        Decryption_ready <= 1'b0;
                        state_q <= StLoad;
                    end else begin
                        x_Plaintext <= pi_q ? '0 : px_q;
                        y_Plaintext <= pi_q ? '0 : py_q;
                        z_Plaintext <= pi_q ? '0 : One;
                        Decryption_ready <= 1'b1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_ec_elgamal_decrypt.sv
// Directed bench for ec_elgamal_decrypt (GF(8), a=b=1, ds=4) with hand-computed results.
module tb_ec_elgamal_decrypt;

    logic clk;
    logic reset;
    logic [2:0] x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
    logic [2:0] x_Plaintext, y_Plaintext, z_Plaintext;
    logic Decryption_ready;

    int errors = 0;
    int checks = 0;

    ec_elgamal_decrypt #(.Ds(4)) dut (
        .clk(clk),
        .reset(reset),
        .x_C1(x_C1),
        .y_C1(y_C1),
        .z_C1(z_C1),
        .x_C2(x_C2),
        .y_C2(y_C2),
        .z_C2(z_C2),
        .x_Plaintext(x_Plaintext),
        .y_Plaintext(y_Plaintext),
        .z_Plaintext(z_Plaintext),
        .Decryption_ready(Decryption_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] ex, input logic [2:0] ey,
                           input logic [2:0] ez, input logic er);
        chk({tag, "_x"}, {1'b0, x_Plaintext}, {1'b0, ex});
        chk({tag, "_y"}, {1'b0, y_Plaintext}, {1'b0, ey});
        chk({tag, "_z"}, {1'b0, z_Plaintext}, {1'b0, ez});
        chk({tag, "_rdy"}, {3'b0, Decryption_ready}, {3'b0, er});
    endtask

    task automatic set_in(input logic [2:0] a1, input logic [2:0] b1, input logic [2:0] c1,
                          input logic [2:0] a2, input logic [2:0] b2, input logic [2:0] c2);
        x_C1 = a1; y_C1 = b1; z_C1 = c1;
        x_C2 = a2; y_C2 = b2; z_C2 = c2;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (Decryption_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rise"}, {3'b0, Decryption_ready}, 4'd1);
    endtask

    task automatic wait_drop(input string tag);
        for (int i = 0; i < 2 && Decryption_ready !== 1'b0; i++) @(negedge clk);
        chk({tag, "_drop"}, {3'b0, Decryption_ready}, 4'd0);
    endtask

    initial begin
        // Reset and first result: C1 of order 2, C2 with Z=3.
        reset = 1'b0;
        set_in(3'd0, 3'd1, 3'd1, 3'd6, 3'd4, 3'd3);
        #10;
        chk_out("reset", 3'd0, 3'd0, 3'd0, 1'b0);
        #10;
        reset = 1'b1;
        wait_ready("t2", 200);
        chk_out("t2", 3'd2, 3'd5, 3'd1, 1'b1);

        // 4*C1 = (7,0) equals C2 up to sign: P = O.
        @(negedge clk);
        set_in(3'd2, 3'd7, 3'd1, 3'd7, 3'd0, 3'd1);
        wait_drop("t3");
        chk_out("t3_hold", 3'd2, 3'd5, 3'd1, 1'b0);
        wait_ready("t3", 200);
        chk_out("t3", 3'd0, 3'd0, 3'd0, 1'b1);

        // Same C1 given projectively with Z=2.
        set_in(3'd4, 3'd5, 3'd2, 3'd7, 3'd0, 3'd1);
        wait_drop("t3b");
        wait_ready("t3b", 200);
        chk_out("t3b", 3'd0, 3'd0, 3'd0, 1'b1);

        // C2 at infinity: P = -(7,0) = (7,7).
        set_in(3'd2, 3'd7, 3'd1, 3'd5, 3'd3, 3'd0);
        wait_drop("t4");
        wait_ready("t4", 200);
        chk_out("t4", 3'd7, 3'd7, 3'd1, 1'b1);

        // C1 at infinity: P = C2, then C2 changes live.
        set_in(3'd2, 3'd7, 3'd0, 3'd2, 3'd5, 3'd1);
        wait_drop("t5");
        wait_ready("t5", 200);
        chk_out("t5", 3'd2, 3'd5, 3'd1, 1'b1);
        set_in(3'd2, 3'd7, 3'd0, 3'd0, 3'd1, 3'd1);
        wait_drop("t5b");
        wait_ready("t5b", 200);
        chk_out("t5b", 3'd0, 3'd1, 3'd1, 1'b1);

        // Reset during the scalar multiply, then a clean recompute.
        set_in(3'd2, 3'd7, 3'd1, 3'd6, 3'd3, 3'd0);
        repeat (14) @(negedge clk);
        chk_out("t6_busy", 3'd0, 3'd1, 3'd1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_out("t6_rst", 3'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready("t6", 200);
        chk_out("t6", 3'd7, 3'd7, 3'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
